// File: rtl/ovc_state_ctrl_pkg.sv
// Shared types and helpers for the output-VC state controller.
// Encodings match the router-wide OVC state values (IDLE/ACTIVE/DRAIN).
package ovc_state_ctrl_pkg;

    localparam int unsigned OVC_V         = 2;
    localparam int unsigned OVC_BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        OVC_IDLE   = 2'b00,
        OVC_ACTIVE = 2'b01,
        OVC_DRAIN  = 2'b10
    } ovc_state_e;

    // Common one-hot test for the alloc, send and credit VC vectors.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/ovc_state_entry.sv
// One output VC: state FSM, credit counter and per-entry protocol errors.
// OVC_EARLY_REALLOC_EN: tail send returns the VC straight to IDLE, skipping DRAIN.
module ovc_state_entry
    import ovc_state_ctrl_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_alloc,
    input  logic i_send,
    input  logic i_send_tail,
    input  logic i_credit,
    output logic o_avail,
    output logic o_cready,
    output logic o_err
);

    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    ovc_state_e    r_state;
    ovc_state_e    w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          r_avail;
    logic          r_cready;
    logic          w_send_ok;
    logic          w_credit_ok;

    // A same-cycle credit covers a send at zero, and a send covers a credit at full.
    assign w_send_ok   = i_send && (r_state != OVC_IDLE) && ((r_cnt != '0) || i_credit);
    assign w_credit_ok = i_credit && ((r_cnt != FULL) || w_send_ok);

    always_comb begin
        w_cnt_d = r_cnt;
        if (w_send_ok && !w_credit_ok) begin
            w_cnt_d = r_cnt - CW'(1);
        end else if (w_credit_ok && !w_send_ok) begin
            w_cnt_d = r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            OVC_IDLE: begin
                if (i_alloc) w_state_d = OVC_ACTIVE;
            end
            OVC_ACTIVE: begin
`ifdef OVC_EARLY_REALLOC_EN
                if (w_send_ok && i_send_tail) w_state_d = OVC_IDLE;
`else
                if (w_send_ok && i_send_tail) w_state_d = OVC_DRAIN;
`endif
            end
            OVC_DRAIN: begin
`ifdef OVC_EARLY_REALLOC_EN
                w_state_d = OVC_IDLE;
`else
                if (w_cnt_d == FULL) w_state_d = OVC_IDLE;
`endif
            end
            default: w_state_d = OVC_IDLE;
        endcase
    end

    assign o_err = (i_alloc && (r_state != OVC_IDLE))
                 || (i_send && !w_send_ok)
                 || (i_credit && !w_credit_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= OVC_IDLE;
            r_cnt    <= FULL;
            r_avail  <= 1'b1;
            r_cready <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_avail  <= (w_state_d == OVC_IDLE);
            r_cready <= (w_state_d == OVC_ACTIVE) && (w_cnt_d != '0);
        end
    end

    assign o_avail  = r_avail;
    assign o_cready = r_cready;

endmodule

// File: rtl/ovc_state_ctrl.sv
// Per-output-port OVC controller: V entries plus one-hot checking and sticky errFlag.
// OVC_EARLY_REALLOC_EN selects early reallocation in each entry (default: via DRAIN).
module ovc_state_ctrl
    import ovc_state_ctrl_pkg::*;
#(
    parameter int BUF_DEPTH = OVC_BUF_DEPTH,
    parameter int CW        = $clog2(BUF_DEPTH + 1),
    parameter int V         = OVC_V
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         allocValid,
    input  logic [V-1:0] allocVC,
    input  logic         sendValid,
    input  logic [V-1:0] sendVC,
    input  logic         sendTail,
    input  logic         creditValid,
    input  logic [V-1:0] creditVC,
    output logic [V-1:0] outVCAvailable,
    output logic [V-1:0] creditReady,
    output logic         errFlag
);

    logic         w_alloc_ok;
    logic         w_send_ok;
    logic         w_credit_ok;
    logic         w_vec_err;
    logic [V-1:0] w_entry_err;
    logic         r_err;

    // A malformed vector discards the whole event, not just the extra bits.
    assign w_alloc_ok  = allocValid  && is_onehot(32'(allocVC));
    assign w_send_ok   = sendValid   && is_onehot(32'(sendVC));
    assign w_credit_ok = creditValid && is_onehot(32'(creditVC));
    assign w_vec_err   = (allocValid && !w_alloc_ok) || (sendValid && !w_send_ok)
                       || (creditValid && !w_credit_ok);

    for (genvar j = 0; j < V; j++) begin : g_vc
        ovc_state_entry #(
            .BUF_DEPTH(BUF_DEPTH),
            .CW       (CW)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .i_alloc    (w_alloc_ok && allocVC[j]),
            .i_send     (w_send_ok && sendVC[j]),
            .i_send_tail(sendTail),
            .i_credit   (w_credit_ok && creditVC[j]),
            .o_avail    (outVCAvailable[j]),
            .o_cready   (creditReady[j]),
            .o_err      (w_entry_err[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_vec_err || (|w_entry_err)) begin
            r_err <= 1'b1;
        end
    end

    assign errFlag = r_err;

endmodule

// File: tb/tb_ovc_state_ctrl.sv
// Self-checking bench for ovc_state_ctrl (V=2, BUF_DEPTH=4): vector table plus
// hand-written reset/corner sequences, expectations routed through a scoreboard queue.
module tb_ovc_state_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       allocValid = 1'b0;
    logic [1:0] allocVC = 2'b00;
    logic       sendValid = 1'b0;
    logic [1:0] sendVC = 2'b00;
    logic       sendTail = 1'b0;
    logic       creditValid = 1'b0;
    logic [1:0] creditVC = 2'b00;
    logic [1:0] outVCAvailable;
    logic [1:0] creditReady;
    logic       errFlag;

    ovc_state_ctrl #(
        .BUF_DEPTH(4),
        .V        (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .allocValid    (allocValid),
        .allocVC       (allocVC),
        .sendValid     (sendValid),
        .sendVC        (sendVC),
        .sendTail      (sendTail),
        .creditValid   (creditValid),
        .creditVC      (creditVC),
        .outVCAvailable(outVCAvailable),
        .creditReady   (creditReady),
        .errFlag       (errFlag)
    );

    always #5 clk = ~clk;

`ifdef OVC_EARLY_REALLOC_EN
    localparam logic [1:0] DRN_AV = 2'b11;
`else
    localparam logic [1:0] DRN_AV = 2'b10;
`endif

    typedef struct {
        bit         pre_rst;
        logic       av;
        logic [1:0] avc;
        logic       sv;
        logic [1:0] svc;
        logic       st;
        logic       cv;
        logic [1:0] cvc;
        logic [1:0] e_avail;
        logic [1:0] e_crdy;
        logic       e_err;
    } vec_t;

    typedef struct {
        logic [1:0] avail;
        logic [1:0] crdy;
        logic       err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t mk(bit pr, logic av, logic [1:0] avc, logic sv, logic [1:0] svc,
                                logic st, logic cv, logic [1:0] cvc, logic [1:0] ea,
                                logic [1:0] ec, logic ee);
        vec_t v;
        v.pre_rst = pr; v.av = av; v.avc = avc; v.sv = sv; v.svc = svc; v.st = st;
        v.cv = cv; v.cvc = cvc; v.e_avail = ea; v.e_crdy = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, " outVCAvailable"}, outVCAvailable, e.avail);
        check({tag, " creditReady"}, creditReady, e.crdy);
        check({tag, " errFlag"}, {1'b0, errFlag}, {1'b0, e.err});
    endtask

    task automatic idle_inputs();
        allocValid = 1'b0; allocVC = 2'b00; sendValid = 1'b0; sendVC = 2'b00;
        sendTail = 1'b0; creditValid = 1'b0; creditVC = 2'b00;
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        e.avail = 2'b11; e.crdy = 2'b00; e.err = 1'b0;
        check_outputs("reset", e);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        string tag;
        if (v.pre_rst) do_reset();
        @(negedge clk);
        allocValid = v.av; allocVC = v.avc; sendValid = v.sv; sendVC = v.svc;
        sendTail = v.st; creditValid = v.cv; creditVC = v.cvc;
        e.avail = v.e_avail; e.crdy = v.e_crdy; e.err = v.e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tag = $sformatf("vec%0d", idx);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            got = sb.pop_front();
            check_outputs(tag, got);
        end
    endtask

    initial begin : main
        exp_t rexp;
        rexp.avail = 2'b11; rexp.crdy = 2'b00; rexp.err = 1'b0;

        // Credit overrun on VC0: four bodies drain the count, fifth (tail) is dropped
        vecs.push_back(mk(1, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b10, 2'b00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 1, 0, 2'b00, 2'b10, 2'b00, 1));
        // Clean packet: 3 bodies + tail, then four credits to leave DRAIN
        vecs.push_back(mk(1, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 1, 0, 2'b00, DRN_AV, 2'b00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01, DRN_AV, 2'b00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01, DRN_AV, 2'b00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01, DRN_AV, 2'b00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01, 2'b11, 2'b00, 0));
        // VC1: down to cnt=2, same-cycle send+credit, then mixed-VC events
        vecs.push_back(mk(0, 1, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b10, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b10, 0, 0, 2'b00, 2'b01, 2'b10, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b10, 0, 0, 2'b00, 2'b01, 2'b10, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b10, 0, 1, 2'b10, 2'b01, 2'b10, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b10, 0, 0, 2'b00, 2'b01, 2'b10, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10, 2'b00, 2'b11, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // VC1 now ACTIVE with cnt=1: asynchronous reset must clear outputs before any edge
        @(negedge clk);
        idle_inputs();
        #1;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", rexp);
        @(negedge clk);
        rst = 1'b0;

        vecs.delete();
        // Realloc of an ACTIVE VC is an error; errFlag stays set
        vecs.push_back(mk(1, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b10, 2'b01, 1));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b10, 2'b01, 1));
        // Non-one-hot grant ignored; send on IDLE VC ignored
        vecs.push_back(mk(1, 1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 1));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b11, 2'b00, 1));
        // Credit at full saturates; zero sendVC with sendValid
        vecs.push_back(mk(1, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10, 2'b11, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 1, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 1));
        // Tail + credit at full: DRAIN for one cycle, then IDLE
        vecs.push_back(mk(1, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b10, 2'b01, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 2'b01, 1, 1, 2'b01, DRN_AV, 2'b00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 100 + i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
